flash_xfer_sequencer: RTL

// - Memory-mapped sequencer that moves a programmable-length block of 16-bit words from the FLASH port into the dual-port buffer's write side.
// - The CPU starts a transfer through IO writes. The block handshakes words from FLASH, generates buffer write strobes and addresses, then raises an interrupt and holds it until the CPU acknowledges.
// - Replaces the fixed 256-word controller/counter pair; the buffer read side is untouched.

---
 rtl/flash_xfer_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/flash_xfer_sequencer.sv
// Moves a CPU-programmed block of 16-bit FLASH words into the buffer write port, then interrupts.
// Optional stall timeout (ERR state, xfer_error) is enabled by defining FLASH_SEQ_TIMEOUT_EN.
module flash_xfer_sequencer #(
  parameter logic [15:0] BASE_ADDR   = 16'h5000,
  parameter int unsigned AW          = 8,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          write_io,
  input  logic [15:0]   addr_bus,
  input  logic [15:0]   data_bus,
  input  logic [15:0]   flash_data,
  input  logic          flash_valid,
  output logic          get_data,
  output logic          buf_we,
  output logic [AW-1:0] buf_waddr,
  output logic [15:0]   buf_wdata,
  output logic          interrupt_en,
  output logic          busy,
  output logic          xfer_error
);

`ifdef FLASH_SEQ_TIMEOUT_EN
  typedef enum logic [1:0] {StIdle, StXfer, StDone, StErr} state_e;
  localparam int unsigned SW = $clog2(TIMEOUT_CYC + 1);
  logic [SW-1:0] stall_q, stall_d;
`else
  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;
`endif

  state_e        state_q, state_d;
  logic [AW-1:0] counter_q, counter_d;
  logic [AW-1:0] last_q, last_d;
  logic          get_data_q, interrupt_q, busy_q;
  logic          start, ack, abort;

  // Only the low AW bits of the START data carry the last word index.
  logic unused_data_hi;
  assign unused_data_hi = ^data_bus[15:AW];

  assign start = write_io && (addr_bus == BASE_ADDR);
  assign ack   = write_io && (addr_bus == BASE_ADDR + 16'd1);
  assign abort = write_io && (addr_bus == BASE_ADDR + 16'd2);

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    last_d    = last_q;
    buf_we    = 1'b0;
`ifdef FLASH_SEQ_TIMEOUT_EN
    stall_d   = stall_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          last_d    = data_bus[AW-1:0];
          counter_d = '0;
          state_d   = StXfer;
`ifdef FLASH_SEQ_TIMEOUT_EN
          stall_d   = '0;
`endif
        end
      end
      StXfer: begin
        if (abort) begin
          state_d = StIdle;
        end else if (flash_valid) begin
          buf_we = 1'b1;
`ifdef FLASH_SEQ_TIMEOUT_EN
          stall_d = '0;
`endif
          // Counter holds on the final word so it never wraps inside a transfer.
          if (counter_q == last_q) begin
            state_d = StDone;
          end else begin
            counter_d = counter_q + AW'(1);
          end
        end else begin
`ifdef FLASH_SEQ_TIMEOUT_EN
          if (stall_q == SW'(TIMEOUT_CYC - 1)) begin
            state_d = StErr;
          end else begin
            stall_d = stall_q + SW'(1);
          end
`endif
        end
      end
      StDone: begin
        if (ack) begin
          state_d = StIdle;
        end
      end
`ifdef FLASH_SEQ_TIMEOUT_EN
      StErr: begin
        if (ack || abort) begin
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Status outputs are decoded from the next state so they line up with the new state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      counter_q   <= '0;
      last_q      <= '0;
      get_data_q  <= 1'b0;
      interrupt_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      last_q      <= last_d;
      get_data_q  <= (state_d == StXfer);
`ifdef FLASH_SEQ_TIMEOUT_EN
      interrupt_q <= (state_d == StDone) || (state_d == StErr);
`else
      interrupt_q <= (state_d == StDone);
`endif
      busy_q      <= (state_d != StIdle);
    end
  end

`ifdef FLASH_SEQ_TIMEOUT_EN
  logic xfer_error_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_q      <= '0;
      xfer_error_q <= 1'b0;
    end else begin
      stall_q      <= stall_d;
      xfer_error_q <= (state_d == StErr);
    end
  end

  assign xfer_error = xfer_error_q;
`else
  assign xfer_error = 1'b0;
`endif

  assign get_data     = get_data_q;
  assign interrupt_en = interrupt_q;
  assign busy         = busy_q;
  assign buf_waddr    = counter_q;
  assign buf_wdata    = flash_data;

endmodule
